// File: rtl/audio_mixer_if.sv
// rtl/audio_mixer_if.sv - sound-source inputs and stereo sample outputs of audio_mixer
interface audio_mixer_if #(
  parameter int CHIPS = 2,
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
);
  logic                  strobe;
  logic                  mic;
  logic                  ear;
  logic                  speaker;
  logic [1:0]            mode;
  logic [CHIPS*IN_W-1:0] a;
  logic [CHIPS*IN_W-1:0] b;
  logic [CHIPS*IN_W-1:0] c;
  logic [7:0]            dac;
  logic [OUT_W-1:0]      left;
  logic [OUT_W-1:0]      right;
  logic                  valid;
  logic                  busy;

  modport master (
    output strobe, mic, ear, speaker, mode, a, b, c, dac,
    input  left, right, valid, busy
  );

  modport slave (
    input  strobe, mic, ear, speaker, mode, a, b, c, dac,
    output left, right, valid, busy
  );
endinterface

// File: rtl/audio_mixer.sv
// rtl/audio_mixer.sv - time-multiplexed stereo mixer: ULA bits, CHIPS AY/YM chips and 8-bit DAC
// Optional DC blocker with signed output when AUDIO_MIXER_DCBLOCK_EN is defined.
module audio_mixer #(
  parameter int CHIPS = 2,
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int DC_K  = 10
) (
  input logic         clock,
  input logic         reset,
  audio_mixer_if.slave bus
);
  localparam int ACC_W = IN_W + 4 + $clog2(CHIPS + 1);
  localparam int IDX_W = $clog2(CHIPS + 1);
  localparam int SUM_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, ACC, FIX, SAT, DC} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [ACC_W-1:0]      acc_l, acc_r;
  logic                  s_mic, s_ear, s_speaker;
  logic [1:0]            s_mode;
  logic [CHIPS*IN_W-1:0] s_a, s_b, s_c;
  logic [7:0]            s_dac;

  logic [IN_W-1:0]  ch_a, ch_b, ch_c;
  logic [ACC_W-1:0] ea, eb, ec, add_l, add_r, fix;
  logic [7:0]       ula_level;
  logic [SUM_W-1:0] sum_l, sum_r;

  function automatic logic [OUT_W-1:0] clamp(input logic [SUM_W-1:0] s);
    if (|s[SUM_W-1:OUT_W]) return {OUT_W{1'b1}};
    return s[OUT_W-1:0];
  endfunction

  always_comb begin
    ch_a = s_a[int'(idx)*IN_W +: IN_W];
    ch_b = s_b[int'(idx)*IN_W +: IN_W];
    ch_c = s_c[int'(idx)*IN_W +: IN_W];
    ea   = ACC_W'(ch_a);
    eb   = ACC_W'(ch_b);
    ec   = ACC_W'(ch_c);
    case (s_mode)
      2'd0:    begin add_l = (ea << 1) + eb; add_r = (ec << 1) + eb; end
      2'd1:    begin add_l = (ea << 1) + ec; add_r = (eb << 1) + ec; end
      default: begin add_l = ea + eb + ec;   add_r = ea + eb + ec;   end
    endcase
  end

  // Perceptual ULA level table, indexed by {speaker, ear, mic}
  always_comb begin
    case ({s_speaker, s_ear, s_mic})
      3'd0:    ula_level = 8'h00;
      3'd1:    ula_level = 8'h24;
      3'd2:    ula_level = 8'h40;
      3'd3:    ula_level = 8'h64;
      3'd4:    ula_level = 8'hB8;
      3'd5:    ula_level = 8'hC0;
      3'd6:    ula_level = 8'hF8;
      default: ula_level = 8'hFF;
    endcase
    fix   = (ACC_W'(ula_level) << (IN_W - 10)) + (ACC_W'(s_dac) << (IN_W - 8));
    sum_l = SUM_W'(acc_l + fix);
    sum_r = SUM_W'(acc_r + fix);
  end

`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int Y_W = OUT_W + 3;

  logic [OUT_W-1:0]        x_l, x_r, xp_l, xp_r;
  logic signed [OUT_W-1:0] yp_l, yp_r, y_l, y_r;

  // y = x - x_prev + y_prev - (y_prev >>> DC_K), saturated to signed OUT_W
  function automatic logic signed [OUT_W-1:0] dc_step(
    input logic [OUT_W-1:0] x, input logic [OUT_W-1:0] xp, input logic signed [OUT_W-1:0] yp);
    logic signed [Y_W-1:0] y;
    logic signed [OUT_W-1:0] yk;
    yk = yp >>> DC_K;
    y  = signed'(Y_W'(x)) - signed'(Y_W'(xp)) + {{3{yp[OUT_W-1]}}, yp} - {{3{yk[OUT_W-1]}}, yk};
    if (y > signed'(Y_W'({1'b0, {(OUT_W-1){1'b1}}}))) return {1'b0, {(OUT_W-1){1'b1}}};
    if (y < -signed'(Y_W'({1'b1, {(OUT_W-1){1'b0}}}))) return {1'b1, {(OUT_W-1){1'b0}}};
    return y[OUT_W-1:0];
  endfunction

  always_comb begin
    y_l = dc_step(x_l, xp_l, yp_l);
    y_r = dc_step(x_r, xp_r, yp_r);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      s_mic     <= 1'b0;
      s_ear     <= 1'b0;
      s_speaker <= 1'b0;
      s_mode    <= 2'd0;
      s_a       <= '0;
      s_b       <= '0;
      s_c       <= '0;
      s_dac     <= 8'd0;
      bus.left  <= '0;
      bus.right <= '0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      x_l  <= '0;
      x_r  <= '0;
      xp_l <= '0;
      xp_r <= '0;
      yp_l <= '0;
      yp_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.valid <= 1'b0;
          if (bus.strobe) begin
            state    <= LOAD;
            bus.busy <= 1'b1;
          end
        end
        LOAD: begin
          s_mic     <= bus.mic;
          s_ear     <= bus.ear;
          s_speaker <= bus.speaker;
          s_mode    <= bus.mode;
          s_a       <= bus.a;
          s_b       <= bus.b;
          s_c       <= bus.c;
          s_dac     <= bus.dac;
          acc_l     <= '0;
          acc_r     <= '0;
          idx       <= '0;
          state     <= ACC;
        end
        ACC: begin
          acc_l <= acc_l + add_l;
          acc_r <= acc_r + add_r;
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(CHIPS - 1)) state <= FIX;
        end
        FIX: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
          x_l <= clamp(sum_l);
          x_r <= clamp(sum_r);
`else
          bus.left  <= clamp(sum_l);
          bus.right <= clamp(sum_r);
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
`endif
          state <= SAT;
        end
        SAT: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
          bus.left  <= y_l;
          bus.right <= y_r;
          xp_l      <= x_l;
          xp_r      <= x_r;
          yp_l      <= y_l;
          yp_r      <= y_r;
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
          state     <= DC;
`else
          bus.valid <= 1'b0;
          state     <= IDLE;
`endif
        end
        DC: begin
          bus.valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mixer.sv
// tb/tb_audio_mixer.sv - directed vector bench for audio_mixer (CHIPS=2, IN_W=12, OUT_W 16 and 14)
module tb_audio_mixer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  audio_mixer_if #(.CHIPS(2), .IN_W(12), .OUT_W(16)) bus0 ();
  audio_mixer_if #(.CHIPS(2), .IN_W(12), .OUT_W(14)) bus1 ();

  audio_mixer #(.CHIPS(2), .IN_W(12), .OUT_W(16)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  audio_mixer #(.CHIPS(2), .IN_W(12), .OUT_W(14)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  typedef struct {
    logic [1:0]  mode;
    logic        speaker, ear, mic;
    logic [23:0] a, b, c;
    logic [7:0]  dac;
    logic [15:0] exp_l, exp_r;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  int   nvalid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    bus0.mode = v.mode; bus0.speaker = v.speaker; bus0.ear = v.ear; bus0.mic = v.mic;
    bus0.a = v.a; bus0.b = v.b; bus0.c = v.c; bus0.dac = v.dac;
  endtask

  // One full mix on dut0; inputs are scrambled once the snapshot has been taken
  task automatic run0(input vec_t v, input string name);
    @(negedge clock);
    drive0(v);
    bus0.strobe = 1'b1;
    @(negedge clock);
    bus0.strobe = 1'b0;
    cyc = 1;
    while (!bus0.valid && cyc < 20) begin
      check({name, " busy"}, 32'(bus0.busy), 32'd1);
      if (cyc == 2) begin
        bus0.a = '1; bus0.b = '1; bus0.c = '1; bus0.dac = 8'hFF;
        bus0.mode = 2'd2; bus0.speaker = 1'b1; bus0.ear = 1'b0; bus0.mic = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd5);
    check({name, " left"}, 32'(bus0.left), 32'(v.exp_l));
    check({name, " right"}, 32'(bus0.right), 32'(v.exp_r));
    check({name, " busy_done"}, 32'(bus0.busy), 32'd0);
    @(negedge clock);
    check({name, " valid_pulse"}, 32'(bus0.valid), 32'd0);
    check({name, " left_hold"}, 32'(bus0.left), 32'(v.exp_l));
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, 24'h0, 8'h00, 16'h0000, 16'h0000};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b0, 24'h100, 24'h010, 24'h001, 8'h00, 16'h0210, 16'h0012};
    vecs[2] = '{2'd1, 1'b0, 1'b0, 1'b0, 24'h100, 24'h010, 24'h001, 8'h00, 16'h0201, 16'h0021};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 24'h100, 24'h010, 24'h001, 8'h00, 16'h0111, 16'h0111};
    vecs[4] = '{2'd0, 1'b1, 1'b1, 1'b1, 24'h0, 24'h0, 24'h0, 8'h80, 16'h0BFC, 16'h0BFC};
    vecs[5] = '{2'd3, 1'b0, 1'b0, 1'b1, 24'h000100, 24'h020000, 24'h003000, 8'h01, 16'h01C3, 16'h01C3};
    vecs[6] = '{2'd0, 1'b0, 1'b1, 1'b0, 24'h00A000, 24'h005000, 24'h003000, 8'h00, 16'h0119, 16'h010B};

    bus0.strobe = 1'b0;
    drive0(vecs[0]);
    bus1.strobe = 1'b0; bus1.mode = 2'd0; bus1.speaker = 1'b0; bus1.ear = 1'b0; bus1.mic = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.dac = 8'h00;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset left", 32'(bus0.left), 32'd0);
    check("reset right", 32'(bus0.right), 32'd0);
    check("reset valid", 32'(bus0.valid), 32'd0);
    check("reset busy", 32'(bus0.busy), 32'd0);

    for (int i = 0; i < 7; i++) run0(vecs[i], $sformatf("vec%0d", i));

    // Clamp at 14-bit full scale, with strobes during busy and in the SAT cycle
    @(negedge clock);
    bus1.a = '1; bus1.b = '1; bus1.c = '1; bus1.dac = 8'hFF; bus1.speaker = 1'b1;
    bus1.strobe = 1'b1;
    @(negedge clock);
    bus1.strobe = 1'b0;
    cyc = 1;
    while (!bus1.valid && cyc < 20) begin
      bus1.strobe = (cyc == 2);
      @(negedge clock);
      cyc++;
    end
    check("clamp latency", 32'(cyc), 32'd5);
    check("clamp left", 32'(bus1.left), 32'h3FFF);
    check("clamp right", 32'(bus1.right), 32'h3FFF);
    bus1.strobe = 1'b1;
    @(negedge clock);
    bus1.strobe = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus1.valid) nvalid++;
      @(negedge clock);
    end
    check("ignored strobes", 32'(nvalid), 32'd0);
    check("ignored busy", 32'(bus1.busy), 32'd0);

    // Reset in cycle 3 of a mix aborts it
    @(negedge clock);
    drive0(vecs[1]);
    bus0.strobe = 1'b1;
    @(negedge clock);
    bus0.strobe = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort left", 32'(bus0.left), 32'd0);
    check("abort right", 32'(bus0.right), 32'd0);
    check("abort busy", 32'(bus0.busy), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.valid) nvalid++;
      @(negedge clock);
    end
    check("abort no valid", 32'(nvalid), 32'd0);
    run0(vecs[2], "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
